// File: rtl/vga_scanout.sv
// VGA scan-out engine: programmable H/V timing with frame-synchronous shadowed config,
// scaled frame-buffer fetch addressing and a two-stage registered colour/sync output.
module vga_scanout #(
  parameter int CW    = 11,
  parameter int AW    = 24,
  parameter int RBITS = 3,
  parameter int GBITS = 3,
  parameter int BBITS = 2
) (
  input  logic                         i_vgaclk,
  input  logic                         i_reset,
  output logic                         o_hSync,
  output logic                         o_vSync,
  output logic [RBITS-1:0]             o_red,
  output logic [GBITS-1:0]             o_green,
  output logic [BBITS-1:0]             o_blue,
  output logic                         o_inth,
  output logic                         o_intv,
  output logic [AW-1:0]                o_pixIdx,
  output logic                         o_pixGate,
  input  logic [RBITS+GBITS+BBITS-1:0] i_pixData,
  input  logic                         i_wb_cyc,
  input  logic                         i_wb_stb,
  input  logic                         i_wb_we,
  input  logic [3:0]                   i_wb_addr,
  input  logic [1:0]                   i_wb_sel,
  input  logic [15:0]                  i_wb_dat,
  output logic [15:0]                  o_wb_dat,
  output logic                         o_wb_ack
);

  typedef struct packed {
    logic [CW-1:0] hss, hbp, hvs, hend, vss, vbp, vvs, vend;
    logic [6:0]    ctrl;
    logic [15:0]   stride;
  } shadow_t;

  // 640x480@60, enabled, active-low syncs, 1x/1x, FB_BASE=0, STRIDE=640
  localparam logic [11:0][15:0] CFG_RST = {16'd640, 16'd0, 16'd0, 16'h0004,
                                           16'd524, 16'd45, 16'd12, 16'd10,
                                           16'd799, 16'd160, 16'd112, 16'd16};
  localparam shadow_t SH_RST = {CW'(16), CW'(112), CW'(160), CW'(799),
                                CW'(10), CW'(12), CW'(45), CW'(524), 7'h04, 16'd640};
  localparam logic [15:0] TMASK   = 16'((32'd1 << CW) - 32'd1);
  localparam logic [15:0] FBHMASK = 16'((32'd1 << (AW - 16)) - 32'd1);

  function automatic logic [15:0] wmask(input logic [3:0] a);
    if (a < 4'd8)        return TMASK;
    else if (a == 4'd8)  return 16'h007F;
    else if (a == 4'd10) return FBHMASK;
    else if (a < 4'd12)  return 16'hFFFF;
    else                 return 16'h0000;
  endfunction

  // Replication count minus one; field value 3 behaves like 2 (4x)
  function automatic logic [1:0] rep_max(input logic [1:0] f);
    case (f)
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  logic [11:0][15:0] cfg;
  shadow_t           sh, sh_live;
  logic [CW-1:0]     h, v;
  logic [AW-1:0]     line_base, xcnt, fb_live;
  logic [1:0]        hsub, rep, hmax, vmax;
  logic              run, frame_end, vis, vline, hact, vact, hs_now, vs_now;
  logic              gate_d, hs_d, vs_d;
  logic              wb_req, wb_wr;
  logic [15:0]       rd_cur, rd_data, wdata, status;

  always_comb begin
    sh_live.hss    = cfg[0][CW-1:0];
    sh_live.hbp    = cfg[1][CW-1:0];
    sh_live.hvs    = cfg[2][CW-1:0];
    sh_live.hend   = cfg[3][CW-1:0];
    sh_live.vss    = cfg[4][CW-1:0];
    sh_live.vbp    = cfg[5][CW-1:0];
    sh_live.vvs    = cfg[6][CW-1:0];
    sh_live.vend   = cfg[7][CW-1:0];
    sh_live.ctrl   = cfg[8][6:0];
    sh_live.stride = cfg[11];
  end

  assign fb_live = {cfg[10][AW-17:0], cfg[9]};

  // A cleared live enable stops the raster at once rather than at frame end
  assign run       = sh.ctrl[2] & cfg[8][2];
  assign frame_end = run && (h == sh.hend) && (v == sh.vend);
  assign vline     = v >= sh.vvs;
  assign vis       = run && (h >= sh.hvs) && vline;
  assign hact      = run && (h >= sh.hss) && (h < sh.hbp);
  assign vact      = run && (v >= sh.vss) && (v < sh.vbp);
  assign hs_now    = hact ? sh.ctrl[0] : ~sh.ctrl[0];
  assign vs_now    = vact ? sh.ctrl[1] : ~sh.ctrl[1];
  assign hmax      = rep_max(sh.ctrl[4:3]);
  assign vmax      = rep_max(sh.ctrl[6:5]);

  assign o_pixGate = vis;
  assign o_pixIdx  = line_base + xcnt;
  assign o_inth    = run && (h == sh.hend);
  assign o_intv    = frame_end;

  // Wishbone register file
  assign wb_req  = i_wb_cyc & i_wb_stb & ~o_wb_ack;
  assign wb_wr   = wb_req & i_wb_we & (i_wb_addr < 4'd12);
  assign status  = {14'd0, run && (h >= sh.hvs), run && vline};
  assign rd_data = (i_wb_addr == 4'd12) ? status : rd_cur;
  assign wdata   = {i_wb_sel[1] ? i_wb_dat[15:8] : rd_cur[15:8],
                    i_wb_sel[0] ? i_wb_dat[7:0]  : rd_cur[7:0]} & wmask(i_wb_addr);

  always_comb begin
    rd_cur = '0;
    if (i_wb_addr < 4'd12) rd_cur = cfg[i_wb_addr];
  end

  always_ff @(posedge i_vgaclk) begin
    if (i_reset) begin
      cfg      <= CFG_RST;
      o_wb_ack <= 1'b0;
      o_wb_dat <= '0;
    end else begin
      o_wb_ack <= wb_req;
      if (wb_req) o_wb_dat <= rd_data;
      if (wb_wr)  cfg[i_wb_addr] <= wdata;
    end
  end

  // Shadow samples the pre-write register value when a write lands on frame end
  always_ff @(posedge i_vgaclk) begin
    if (i_reset)                 sh <= SH_RST;
    else if (!run || frame_end)  sh <= sh_live;
  end

  always_ff @(posedge i_vgaclk) begin
    if (i_reset || !run) begin
      h <= '0;
      v <= '0;
    end else if (h == sh.hend) begin
      h <= '0;
      v <= (v == sh.vend) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  always_ff @(posedge i_vgaclk) begin
    if (i_reset) begin
      line_base <= '0;
      xcnt      <= '0;
      hsub      <= '0;
      rep       <= '0;
    end else if (!run || frame_end) begin
      line_base <= fb_live;
      xcnt      <= '0;
      hsub      <= '0;
      rep       <= '0;
    end else if (h == sh.hend) begin
      xcnt <= '0;
      hsub <= '0;
      if (vline) begin
        if (rep == vmax) begin
          rep       <= '0;
          line_base <= line_base + AW'(sh.stride);
        end else begin
          rep <= rep + 1'b1;
        end
      end
    end else if (vis) begin
      if (hsub == hmax) begin
        hsub <= '0;
        xcnt <= xcnt + 1'b1;
      end else begin
        hsub <= hsub + 1'b1;
      end
    end
  end

  // Stage 1 waits for memory data, stage 2 registers colour; syncs ride along
  always_ff @(posedge i_vgaclk) begin
    if (i_reset) begin
      gate_d  <= 1'b0;
      hs_d    <= 1'b1;
      vs_d    <= 1'b1;
      o_hSync <= 1'b1;
      o_vSync <= 1'b1;
      o_red   <= '0;
      o_green <= '0;
      o_blue  <= '0;
    end else begin
      gate_d  <= vis;
      hs_d    <= hs_now;
      vs_d    <= vs_now;
      o_hSync <= hs_d;
      o_vSync <= vs_d;
      o_red   <= gate_d ? i_pixData[RBITS-1:0] : '0;
      o_green <= gate_d ? i_pixData[RBITS+GBITS-1:RBITS] : '0;
      o_blue  <= gate_d ? i_pixData[RBITS+GBITS+BBITS-1:RBITS+GBITS] : '0;
    end
  end

endmodule
